// File: rtl/cpu_pkg.sv
// Shared constants for the fetch/data memory arbiter: FSM state encodings,
// grant encodings, default timeout and the wait-counter sizing helper.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

  // Bits needed to hold TIMEOUT-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned timeout);
    if (timeout <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(timeout);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and shared memory bus seen by mem_arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface mem_arbiter_if #(
  parameter int XLEN = 32
) ();

  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_rdata;
  logic            i_err;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_wstrb;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker; req_i[0] is fetch, req_i[1] is data.
// last_grant advances only when enabled and a grant is actually made.
module arb_rr2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       valid_o,
  output logic       gnt_o
);

  logic last_q;
  logic last_d;

  // Pick a port; on contention favour the one not granted last.
  always_comb begin
    valid_o = en_i & (req_i[0] | req_i[1]);
    if (req_i[0] && req_i[1]) begin
      gnt_o = (last_q == GNT_D) ? GNT_I : GNT_D;
    end else if (req_i[0]) begin
      gnt_o = GNT_I;
    end else begin
      gnt_o = GNT_D;
    end
    if (valid_o) begin
      last_d = gnt_o;
    end else begin
      last_d = last_q;
    end
  end

  // Reset to data so fetch wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= GNT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory bus with one
// transaction outstanding, a bounded wait for mem_ack and a one-cycle port ack.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 32'd1);

  logic [1:0]      state_q, state_d;
  logic            grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            i_ack_q, i_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            arb_valid_s;
  logic            arb_gnt_s;

  arb_rr2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q == ST_IDLE),
    .req_i   ({bus.d_req, bus.i_req}),
    .valid_o (arb_valid_s),
    .gnt_o   (arb_gnt_s)
  );

  // Next-state logic; ack wins over a coincident timeout.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          grant_d   = arb_gnt_s;
          state_d   = ST_ISSUE;
          mem_req_d = 1'b1;
          cnt_d     = {CW{1'b0}};
          if (arb_gnt_s == GNT_I) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = {XLEN{1'b0}};
            mem_wstrb_d = 4'h0;
          end else begin
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_wstrb_d = bus.d_wstrb;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ack || (cnt_q == CNT_MAX)) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          i_ack_d   = (grant_q == GNT_I);
          d_ack_d   = (grant_q == GNT_D);
          if (bus.mem_ack) begin
            rdata_d = mem_we_q ? {XLEN{1'b0}} : bus.mem_rdata;
            err_d   = 1'b0;
          end else begin
            rdata_d = {XLEN{1'b0}};
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_D;
      cnt_q       <= {CW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      mem_wstrb_q <= 4'h0;
      rdata_q     <= {XLEN{1'b0}};
      err_q       <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = rdata_q;
  assign bus.i_err     = err_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = rdata_q;
  assign bus.d_err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when a
// request is driven and popped when the arbiter acknowledges a port.
module tb_mem_arbiter;
  import cpu_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic        port_i;
    logic        port_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  hi;
    logic        single;
    logic        stable;
    logic        to;
  } txn_t;

  txn_t sb_q[$];
  txn_t got;
  txn_t exp_v;
  int   checks   = 0;
  int   failures = 0;

  // Reference model of one transaction as seen on the memory bus and the port.
  function automatic txn_t model(input logic port, input logic [31:0] addr, input logic we,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int ack_at, input logic [31:0] rd);
    txn_t t;
    t        = '0;
    t.port_i = (port == GNT_I);
    t.port_d = (port == GNT_D);
    t.addr   = addr;
    t.we     = we;
    t.wdata  = we ? wdata : 32'h0;
    t.strb   = we ? strb : 4'h0;
    t.hi     = (ack_at == 0) ? 8'(TO) : 8'(ack_at);
    t.rdata  = (ack_at == 0 || we) ? 32'h0 : rd;
    t.err    = (ack_at == 0);
    t.single = 1'b1;
    t.stable = 1'b1;
    t.to     = 1'b0;
    return t;
  endfunction

  // Memory responder: waits for mem_req, acks on cycle ack_at (0 = never), records the port response.
  task automatic transact(input int ack_at, input logic [31:0] rd, input bit drop_i, input bit drop_d);
    int n;
    int c;
    logic [31:0] a, wd;
    logic w;
    logic [3:0] s;
    got = '0;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.mem_req !== 1'b1) begin
      got.to = 1'b1;
      return;
    end
    a  = bus.mem_addr;
    w  = bus.mem_we;
    wd = bus.mem_wdata;
    s  = bus.mem_wstrb;
    got.addr   = a;
    got.we     = w;
    got.wdata  = w ? wd : 32'h0;
    got.strb   = w ? s : 4'h0;
    got.stable = 1'b1;
    c = 1;
    while (bus.mem_req === 1'b1 && c < 60) begin
      if (bus.mem_addr !== a || bus.mem_we !== w || bus.mem_wdata !== wd || bus.mem_wstrb !== s)
        got.stable = 1'b0;
      got.hi = got.hi + 8'd1;
      bus.mem_ack   = (c == ack_at);
      bus.mem_rdata = (c == ack_at) ? rd : 32'hA5A5_5A5A;
      @(negedge clk);
      c++;
    end
    bus.mem_ack = 1'b0;
    if (bus.mem_req === 1'b1) begin
      got.to = 1'b1;
      return;
    end
    got.port_i = bus.i_ack;
    got.port_d = bus.d_ack;
    got.rdata  = bus.i_ack ? bus.i_rdata : bus.d_rdata;
    got.err    = bus.i_ack ? bus.i_err : bus.d_err;
    if (drop_i) bus.i_req = 1'b0;
    if (drop_d) bus.d_req = 1'b0;
    @(negedge clk);
    got.single = !(bus.i_ack || bus.d_ack);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 70'h0) begin
      failures++;
      $display("FAIL reset_mem_bus got=%h exp=0", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
    end
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err} !== 4'h0) begin
      failures++;
      $display("FAIL reset_ack_err got=%b exp=0000", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err});
    end
    checks++;
    if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", {bus.i_rdata, bus.d_rdata});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%b exp=0", bus.mem_req);
    end
  endtask

  task automatic test_fetch();
    sb_q.push_back(model(GNT_I, 32'h100, 1'b0, 32'h0, 4'h0, 3, 32'h0050_0093));
    bus.i_addr = 32'h100;
    bus.i_req  = 1'b1;
    transact(3, 32'h0050_0093, 1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL fetch got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    sb_q.push_back(model(GNT_I, 32'h1000, 1'b0, 32'h0, 4'h0, 2, 32'h1111_0000));
    sb_q.push_back(model(GNT_D, 32'h2000, 1'b0, 32'h0, 4'h0, 1, 32'h2222_0000));
    bus.i_addr = 32'h1000;
    bus.d_addr = 32'h2000;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    transact(2, 32'h1111_0000, 1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL contention_first got=%h exp=%h", got, exp_v);
    end
    transact(1, 32'h2222_0000, 1'b0, 1'b1);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL contention_second got=%h exp=%h", got, exp_v);
    end
    // Both held: grants alternate I, D, I, D.
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(model((k % 2 == 0) ? GNT_I : GNT_D, (k % 2 == 0) ? 32'h1000 : 32'h2000,
                           1'b0, 32'h0, 4'h0, 1 + (k % 3), 32'h3000_0000 + 32'(k)));
    end
    for (int k = 0; k < 4; k++) begin
      transact(1 + (k % 3), 32'h3000_0000 + 32'(k), 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL alternate_%0d got=%h exp=%h", k, got, exp_v);
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    sb_q.push_back(model(GNT_D, 32'h2004, 1'b1, 32'hDEAD_BEEF, 4'h3, 1, 32'hFFFF_FFFF));
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h2004;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_wstrb = 4'h3;
    bus.d_req   = 1'b1;
    transact(1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    bus.d_we = 1'b0;
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL store got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_timeout();
    sb_q.push_back(model(GNT_I, 32'h400, 1'b0, 32'h0, 4'h0, 0, 32'h0));
    bus.i_addr = 32'h400;
    bus.i_req  = 1'b1;
    transact(0, 32'h0, 1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL timeout got=%h exp=%h", got, exp_v);
    end
    sb_q.push_back(model(GNT_I, 32'h404, 1'b0, 32'h0, 4'h0, TO, 32'h1234_5678));
    bus.i_addr = 32'h404;
    bus.i_req  = 1'b1;
    transact(TO, 32'h1234_5678, 1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL ack_on_timeout_cycle got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  bad;
    bus.i_addr = 32'h300;
    bus.i_req  = 1'b1;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_issue got=%b exp=1", bus.mem_req);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_req_drop got=%b exp=0", bus.mem_req);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.mem_req !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_ack got=%b exp=0", bad);
    end
    sb_q.push_back(model(GNT_D, 32'h500, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D));
    bus.d_addr = 32'h500;
    bus.d_req  = 1'b1;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL post_reset_idle_latency got=%0d exp=1", n);
    end
    transact(2, 32'h0BAD_F00D, 1'b0, 1'b1);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL post_reset_txn got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit dup;
    sb_q.push_back(model(GNT_I, 32'h600, 1'b0, 32'h0, 4'h0, 2, 32'hC0DE_0001));
    sb_q.push_back(model(GNT_I, 32'h604, 1'b0, 32'h0, 4'h0, 1, 32'hC0DE_0002));
    bus.i_addr = 32'h600;
    bus.i_req  = 1'b1;
    transact(2, 32'hC0DE_0001, 1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", got, exp_v);
    end
    // Now one cycle after the ack: re-raise.
    bus.i_addr = 32'h604;
    bus.i_req  = 1'b1;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n + 1 !== 2) begin
      failures++;
      $display("FAIL b2b_gap got=%0d exp=2", n + 1);
    end
    transact(1, 32'hC0DE_0002, 1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=%h", got, exp_v);
    end
    dup = 1'b0;
    repeat (6) begin
      if (bus.mem_req !== 1'b0) dup = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (dup !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_duplicate got=%b exp=0", dup);
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.d_wstrb   = 4'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles waited for mem_ack before aborting; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 i_req  input  1  fetch request; held with i_addr stable until i_ack.
REQ-006 i_addr  input  XLEN  fetch byte address.
REQ-007 i_ack  output  1  one-cycle fetch completion pulse.
REQ-008 i_rdata  output  XLEN  fetch data; valid while i_ack is high.
REQ-009 i_err  output  1  fetch timed out; valid while i_ack is high.
REQ-010 d_req, d_we, d_addr[XLEN], d_wdata[XLEN], d_wstrb[4]  input  data request/write-enable/address/write data/byte strobes; held stable until d_ack.
REQ-011 d_ack, d_rdata[XLEN], d_err  output  data-port equivalents of i_ack/i_rdata/i_err.
REQ-012 mem_req, mem_we, mem_addr[XLEN], mem_wdata[XLEN], mem_wstrb[4]  output  shared single-port memory request bus, registered.
REQ-013 mem_ack  input  1  memory completion, one cycle; mem_rdata  input  XLEN  read data, valid with mem_ack.

Function
REQ-014 FSM states: IDLE, ISSUE, RESP; exactly one transaction outstanding.
REQ-015 IDLE: if no request, stay; otherwise grant one port, latch its address/data/we/strb onto the mem_* registers, go to ISSUE.
REQ-016 Arbitration in IDLE: single requester is granted; both requesting -> grant the port not granted last (round robin); last_grant register updates on every grant.
REQ-017 ISSUE: mem_req=1 with stable mem_* fields; the edge after the cycle in which mem_req is first asserted counts as cycle 1 of the wait.
REQ-018 ISSUE and mem_ack=1: capture mem_rdata, err=0, drop mem_req at the next edge, go to RESP.
REQ-019 ISSUE, no mem_ack, wait counter = TIMEOUT-1: drop mem_req, rdata=0, err=1, go to RESP.
REQ-020 mem_ack coincident with the timeout cycle: the ack wins, err=0.
REQ-021 RESP: assert the granted port's ack for exactly one cycle with captured rdata/err; the other port's ack stays 0; next state IDLE.
REQ-022 Requests are not re-sampled in RESP, so a requester dropping req after its ack is never double-granted.
REQ-023 Latency: req sampled in IDLE at edge N -> mem_req high from N+1; mem_ack at cycle K -> port ack at cycle K+1; minimum round trip is 3 cycles.
REQ-024 For writes (mem_we=1), rdata is 0 on ack.
REQ-025 mem_ack outside ISSUE is ignored.
REQ-026 The wait counter is wide enough for TIMEOUT-1, clears on entering ISSUE, and never wraps.

Reset
REQ-027 rst=0 at a clock edge: state=IDLE; mem_req=mem_we=0; mem_addr=mem_wdata=0; mem_wstrb=0; i_ack=d_ack=i_err=d_err=0; i_rdata=d_rdata=0; counter=0; last_grant=data port, so fetch wins the first contention.
REQ-028 Reset mid-transaction aborts with no ack to either port; a late mem_ack is ignored per REQ-025.

Structure
REQ-029 Shared package/header cpu_pkg holds the FSM state encodings (IDLE/ISSUE/RESP), the grant encodings (GNT_I/GNT_D) and the default TIMEOUT constant.
REQ-030 One sub-module, arb_rr2: two-requester round-robin picker with a last_grant register and an enable input, instantiated once.

Verification
REQ-031 Fetch only: i_req=1, i_addr=0x100; mem_ack 2 cycles after mem_req with rdata 0x00500093 -> mem_addr=0x100, i_ack one cycle, i_rdata=0x00500093, i_err=0.
REQ-032 Contention after reset: i_req and d_req both 1 -> fetch granted first, then data; repeat with both held -> grants alternate I, D, I, D.
REQ-033 Store: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=0x3 -> mem_* fields match exactly, d_ack with d_rdata=0, i_ack stays 0.
REQ-034 Timeout: TIMEOUT=8, mem_ack never asserted -> mem_req high for exactly 8 cycles, then i_ack with i_err=1 and i_rdata=0; also mem_ack on cycle 8 -> err=0.
REQ-035 Reset mid-ISSUE: rst=0 for one cycle, then mem_ack pulse -> mem_req=0 at the next edge, no ack to either port, FSM in IDLE.
REQ-036 Back-to-back: requester re-raises req the cycle after its ack -> new mem_req follows exactly 2 cycles after the ack; no duplicate grant.
